// File: rtl/ibuf_pkg.sv
// Shared types and width helpers for the ping-pong input buffer and its banks.
package ibuf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a count that must reach n itself.
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ibuf_bank.sv
// One vector bank: word storage with indexed write, optional bulk clear and a length register.
module ibuf_bank
    import ibuf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_IN   = 8
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic                       i_clear,
    input  logic [idx_w(N_IN)-1:0]     i_wr_idx,
    input  logic [DATA_W-1:0]          i_wr_data,
    output logic [N_IN*DATA_W-1:0]     o_words,
    output logic [len_w(N_IN)-1:0]     o_len
);

    localparam int IDX_W = idx_w(N_IN);
    localparam int LEN_W = len_w(N_IN);

    logic [N_IN*DATA_W-1:0] r_words;
    logic [LEN_W-1:0]       r_len;

    // Clear applies to the whole bank; the word written in the same cycle still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words <= '0;
            r_len   <= '0;
        end else begin
            if (i_clear) begin
                r_words <= '0;
            end
            for (int i = 0; i < N_IN; i++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    r_words[i*DATA_W +: DATA_W] <= i_wr_data;
                end
            end
            if (i_wr_en) begin
                r_len <= LEN_W'(i_wr_idx) + LEN_W'(1);
            end
        end
    end

    assign o_words = r_words;
    assign o_len   = r_len;

endmodule

// File: rtl/pingpong_input_buffer.sv
// Collects producer words into N_BANKS vector banks and presents completed vectors in order.
// Define IBUF_ZERO_PAD_EN to zero a bank as it starts filling, so words beyond vec_len read 0.
module pingpong_input_buffer
    import ibuf_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int N_IN    = 8,
    parameter int N_BANKS = 2
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_W-1:0]     data_in,
    input  logic                         data_in_valid,
    input  logic                         vector_last,
    output logic                         data_in_ready,
    output logic [N_IN*DATA_W-1:0]       invec_bus,
    output logic [$clog2(N_IN+1)-1:0]    vec_len,
    output logic                         vec_valid,
    input  logic                         vec_ready
);

    localparam int IDX_W  = idx_w(N_IN);
    localparam int LEN_W  = len_w(N_IN);
    localparam int BANK_W = idx_w(N_BANKS);

    bank_state_e            r_state [N_BANKS];
    logic [BANK_W-1:0]      r_wr_bank;
    logic [BANK_W-1:0]      r_rd_bank;
    logic [IDX_W-1:0]       r_wr_idx;

    logic [N_IN*DATA_W-1:0] w_bank_words [N_BANKS];
    logic [LEN_W-1:0]       w_bank_len   [N_BANKS];
    logic [N_BANKS-1:0]     w_bank_we;
    logic [N_BANKS-1:0]     w_bank_clr;
    logic                   w_wr_fire;
    logic                   w_rd_fire;
    logic                   w_close;
    logic [BANK_W-1:0]      w_wr_bank_nxt;
    logic [BANK_W-1:0]      w_rd_bank_nxt;

    // Handshakes depend only on registered bank state, never on the partner's valid/ready.
    assign data_in_ready = (r_state[r_wr_bank] != BANK_FULL);
    assign vec_valid     = (r_state[r_rd_bank] == BANK_FULL);
    assign invec_bus     = w_bank_words[r_rd_bank];
    assign vec_len       = w_bank_len[r_rd_bank];

    assign w_wr_fire = data_in_valid && data_in_ready;
    assign w_rd_fire = vec_valid && vec_ready;
    assign w_close   = w_wr_fire && (vector_last || (r_wr_idx == IDX_W'(N_IN - 1)));

    assign w_wr_bank_nxt = (r_wr_bank == BANK_W'(N_BANKS - 1)) ? BANK_W'(0) : r_wr_bank + BANK_W'(1);
    assign w_rd_bank_nxt = (r_rd_bank == BANK_W'(N_BANKS - 1)) ? BANK_W'(0) : r_rd_bank + BANK_W'(1);

    // Per-bank write enable and, when padding is built in, clear on the first word of a vector.
    always_comb begin
        w_bank_we  = '0;
        w_bank_clr = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            w_bank_we[b] = w_wr_fire && (r_wr_bank == BANK_W'(b));
`ifdef IBUF_ZERO_PAD_EN
            w_bank_clr[b] = w_bank_we[b] && (r_state[b] == BANK_EMPTY);
`else
            w_bank_clr[b] = 1'b0;
`endif
        end
    end

    // Bank states and pointers; a read and a write never target the same bank in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < N_BANKS; b++) begin
                r_state[b] <= BANK_EMPTY;
            end
            r_wr_bank <= '0;
            r_rd_bank <= '0;
            r_wr_idx  <= '0;
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (w_rd_fire && (r_rd_bank == BANK_W'(b))) begin
                    r_state[b] <= BANK_EMPTY;
                end else if (w_bank_we[b]) begin
                    r_state[b] <= w_close ? BANK_FULL : BANK_FILLING;
                end
            end
            if (w_wr_fire) begin
                if (w_close) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= w_wr_bank_nxt;
                end else begin
                    r_wr_idx  <= r_wr_idx + IDX_W'(1);
                end
            end
            if (w_rd_fire) begin
                r_rd_bank <= w_rd_bank_nxt;
            end
        end
    end

    for (genvar gb = 0; gb < N_BANKS; gb++) begin : g_bank
        ibuf_bank #(
            .DATA_W (DATA_W),
            .N_IN   (N_IN)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_bank_we[gb]),
            .i_clear   (w_bank_clr[gb]),
            .i_wr_idx  (r_wr_idx),
            .i_wr_data (data_in),
            .o_words   (w_bank_words[gb]),
            .o_len     (w_bank_len[gb])
        );
    end

endmodule

// File: tb/tb_pingpong_input_buffer.sv
// Scoreboard bench for pingpong_input_buffer: a bank model predicts each presented vector.
module tb_pingpong_input_buffer;

    localparam int DATA_W  = 16;
    localparam int N_IN    = 8;
    localparam int N_BANKS = 2;
    localparam int LEN_W   = $clog2(N_IN + 1);

    typedef struct {
        logic [N_IN*DATA_W-1:0] bus;
        int                     len;
    } vec_t;

    logic                      clk;
    logic                      rst;
    logic [DATA_W-1:0]         data_in;
    logic                      data_in_valid;
    logic                      vector_last;
    logic                      data_in_ready;
    logic [N_IN*DATA_W-1:0]    invec_bus;
    logic [LEN_W-1:0]          vec_len;
    logic                      vec_valid;
    logic                      vec_ready;

    vec_t                      q[$];
    logic [N_IN*DATA_W-1:0]    m_mem [N_BANKS];
    int                        m_idx;
    int                        m_bank;
    int                        n_chk;
    int                        n_err;
    int                        n_pop;

    pingpong_input_buffer #(
        .DATA_W  (DATA_W),
        .N_IN    (N_IN),
        .N_BANKS (N_BANKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .vector_last   (vector_last),
        .data_in_ready (data_in_ready),
        .invec_bus     (invec_bus),
        .vec_len       (vec_len),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model/scoreboard: at each falling edge predict what the next rising edge will do.
    initial begin
        vec_t e;
        m_idx  = 0;
        m_bank = 0;
        for (int b = 0; b < N_BANKS; b++) m_mem[b] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                for (int b = 0; b < N_BANKS; b++) m_mem[b] = '0;
                m_idx  = 0;
                m_bank = 0;
            end else begin
                if (vec_valid && vec_ready) begin
                    n_pop++;
                    n_chk++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_underflow: vector presented (len %0d) with none expected", vec_len);
                    end else begin
                        e = q.pop_front();
                        if (invec_bus !== e.bus) begin
                            n_err++;
                            $display("FAIL sb_bus: got %h expected %h", invec_bus, e.bus);
                        end
                        n_chk++;
                        if (vec_len !== LEN_W'(e.len)) begin
                            n_err++;
                            $display("FAIL sb_len: got %0d expected %0d", vec_len, e.len);
                        end
                    end
                end
                if (data_in_valid && data_in_ready) begin
`ifdef IBUF_ZERO_PAD_EN
                    if (m_idx == 0) m_mem[m_bank] = '0;
`endif
                    m_mem[m_bank][m_idx*DATA_W +: DATA_W] = data_in;
                    if (vector_last || (m_idx == N_IN - 1)) begin
                        e.bus = m_mem[m_bank];
                        e.len = m_idx + 1;
                        q.push_back(e);
                        m_idx  = 0;
                        m_bank = (m_bank + 1) % N_BANKS;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
    end

    task automatic drive_word(input logic [DATA_W-1:0] d, input logic last, output int stalls);
        data_in_valid = 1'b1;
        data_in       = d;
        vector_last   = last;
        stalls        = 0;
        while (!data_in_ready && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (!data_in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL drive_timeout: word %h not accepted within 50 cycles", d);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        data_in_valid = 1'b0;
        vector_last   = 1'b0;
    endtask

    task automatic wait_drain(output int ok);
        vec_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && !vec_valid) ok = 1;
            if (ok == 1) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", data_in_ready); end
        n_chk++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", vec_valid); end
        n_chk++; if (vec_len !== LEN_W'(0)) begin n_err++; $display("FAIL reset_len: got %0d expected 0", vec_len); end
        n_chk++; if (invec_bus !== '0) begin n_err++; $display("FAIL reset_bus: got %h expected 0", invec_bus); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_vector();
        int st, ok, p0;
        p0 = n_pop;
        vec_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive_word(DATA_W'(i), (i == 8), st);
            if (i == 7) begin
                n_chk++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b expected 0", vec_valid); end
            end
        end
        idle();
        n_chk++; if (vec_valid !== 1'b1) begin n_err++; $display("FAIL single_latency: vec_valid %b expected 1", vec_valid); end
        n_chk++; if (vec_len !== LEN_W'(8)) begin n_err++; $display("FAIL single_len: got %0d expected 8", vec_len); end
        n_chk++; if (invec_bus[DATA_W-1:0] !== 16'd1 || invec_bus[N_IN*DATA_W-1 -: DATA_W] !== 16'd8) begin
            n_err++; $display("FAIL single_words: got %h expected word0=1 word7=8", invec_bus);
        end
        wait_drain(ok);
        n_chk++; if (ok !== 1 || n_pop - p0 !== 1) begin n_err++; $display("FAIL single_drain: ok %0d pops %0d expected 1", ok, n_pop - p0); end
    endtask

    task automatic test_short_vector();
        int st, ok;
        logic [DATA_W-1:0] words [3];
        words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033;
        vec_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_word(words[i], (i == 2), st);
        idle();
        n_chk++; if (vec_valid !== 1'b1) begin n_err++; $display("FAIL short_valid: got %b expected 1", vec_valid); end
        n_chk++; if (vec_len !== LEN_W'(3)) begin n_err++; $display("FAIL short_len: got %0d expected 3", vec_len); end
        n_chk++; if (invec_bus[3*DATA_W-1 -: DATA_W] !== 16'h0033) begin n_err++; $display("FAIL short_word2: got %h expected 0033", invec_bus[3*DATA_W-1 -: DATA_W]); end
`ifdef IBUF_ZERO_PAD_EN
        n_chk++; if (invec_bus[N_IN*DATA_W-1:3*DATA_W] !== '0) begin n_err++; $display("FAIL short_pad: got %h expected 0", invec_bus[N_IN*DATA_W-1:3*DATA_W]); end
`endif
        wait_drain(ok);
        n_chk++; if (ok !== 1) begin n_err++; $display("FAIL short_drain: ok %0d expected 1", ok); end
    endtask

    task automatic test_backpressure();
        int st, ok, p0;
        p0 = n_pop;
        vec_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            drive_word(DATA_W'(16'h0200 + i), 1'b0, st);
            if (i == 8) begin
                n_chk++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_mid: got %b expected 1", data_in_ready); end
            end
        end
        n_chk++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: ready %b expected 0", data_in_ready); end
        data_in_valid = 1'b1;
        data_in       = 16'h0211;
        vector_last   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold: ready %b expected 0", data_in_ready); end
        vec_ready = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b0;
        n_chk++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: ready %b expected 1", data_in_ready); end
        for (int i = 17; i <= 24; i++) drive_word(DATA_W'(16'h0200 + i), 1'b0, st);
        idle();
        wait_drain(ok);
        n_chk++; if (ok !== 1 || n_pop - p0 !== 3) begin n_err++; $display("FAIL bp_drain: ok %0d pops %0d expected 3", ok, n_pop - p0); end
    endtask

    task automatic test_back_to_back();
        int st, stalls, drops, ok, p0;
        p0 = n_pop; stalls = 0; drops = 0;
        vec_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_word(DATA_W'($urandom), ((i % 8) == 7), st);
            stalls += st;
            if (!data_in_ready) drops++;
        end
        idle();
        n_chk++; if (stalls !== 0 || drops !== 0) begin n_err++; $display("FAIL b2b_rate: stalls %0d drops %0d expected 0", stalls, drops); end
        wait_drain(ok);
        n_chk++; if (ok !== 1 || n_pop - p0 !== 5) begin n_err++; $display("FAIL b2b_count: ok %0d pops %0d expected 5", ok, n_pop - p0); end
    endtask

    task automatic test_reset_mid();
        int st, ok, p0, seen;
        vec_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_word(DATA_W'(16'h0300 + i), 1'b0, st);
        rst           = 1'b1;
        data_in_valid = 1'b1;
        data_in       = 16'h0399;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        n_chk++; if (vec_valid !== 1'b0 || vec_len !== LEN_W'(0) || invec_bus !== '0) begin
            n_err++; $display("FAIL rstmid_clear: valid %b len %0d bus %h expected 0", vec_valid, vec_len, invec_bus);
        end
        n_chk++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", data_in_ready); end
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (vec_valid) seen++;
        end
        n_chk++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_stale: vec_valid high %0d cycles expected 0", seen); end
        p0 = n_pop;
        vec_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive_word(DATA_W'(16'h00A0 + i), (i == 7), st);
        idle();
        n_chk++; if (vec_valid !== 1'b1 || invec_bus[DATA_W-1:0] !== 16'h00A0) begin
            n_err++; $display("FAIL rstmid_next: valid %b word0 %h expected 1 and 00a0", vec_valid, invec_bus[DATA_W-1:0]);
        end
        wait_drain(ok);
        n_chk++; if (ok !== 1 || n_pop - p0 !== 1) begin n_err++; $display("FAIL rstmid_drain: ok %0d pops %0d expected 1", ok, n_pop - p0); end
    endtask

    task automatic test_overflow();
        int st, ok, p0;
        p0 = n_pop;
        vec_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_word(DATA_W'(16'h0100 + i), 1'b0, st);
            if (i == 7) begin
                n_chk++; if (vec_valid !== 1'b1 || vec_len !== LEN_W'(8)) begin
                    n_err++; $display("FAIL ovf_close: valid %b len %0d expected 1 and 8", vec_valid, vec_len);
                end
            end
        end
        n_chk++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL ovf_ninth: vec_valid %b expected 0", vec_valid); end
        drive_word(16'h0109, 1'b1, st);
        idle();
        n_chk++; if (vec_len !== LEN_W'(2) || invec_bus[DATA_W-1:0] !== 16'h0108) begin
            n_err++; $display("FAIL ovf_next: len %0d word0 %h expected 2 and 0108", vec_len, invec_bus[DATA_W-1:0]);
        end
        wait_drain(ok);
        n_chk++; if (ok !== 1 || n_pop - p0 !== 2) begin n_err++; $display("FAIL ovf_drain: ok %0d pops %0d expected 2", ok, n_pop - p0); end
    endtask

    initial begin
        n_chk = 0; n_err = 0; n_pop = 0;
        rst = 1'b1; data_in = '0; data_in_valid = 1'b0; vector_last = 1'b0; vec_ready = 1'b0;
        test_reset();
        test_single_vector();
        test_short_vector();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_overflow();
        n_chk++; if (q.size() !== 0) begin n_err++; $display("FAIL sb_leftover: %0d vectors never presented", q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
